// File: rtl/reg_readback_tx_if.sv
// Register readback bus: a read-request strobe with its address, the register
// values offered for readback, and the UART response line with its busy flag.
interface reg_readback_tx_if;
  logic        rd_req_in;
  logic [2:0]  rd_addr_in;
  logic [7:0]  ctrl_in;
  logic [7:0]  sat_id_in;
  logic [7:0]  doppler_in;
  logic [15:0] ca_phase_in;
  logic [7:0]  snr_in;
  logic        tx_out;
  logic        busy_out;

  modport master (
    output rd_req_in, rd_addr_in, ctrl_in, sat_id_in, doppler_in, ca_phase_in, snr_in,
    input  tx_out, busy_out
  );

  modport slave (
    input  rd_req_in, rd_addr_in, ctrl_in, sat_id_in, doppler_in, ca_phase_in, snr_in,
    output tx_out, busy_out
  );
endinterface

// File: rtl/reg_readback_tx.sv
// Register readback over UART 8N1: each request returns {address byte, data byte}.
// Define READBACK_CHECKSUM_EN to append a third byte, address byte XOR data byte.
module reg_readback_tx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  reg_readback_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef READBACK_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [2:0]       addr_q;
  logic [7:0]       data_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;

  logic [7:0]       sel_data;
  logic [7:0]       cur_byte;
  logic             bit_done;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_data = 8'h00;
    case (bus.rd_addr_in)
      3'b000:  sel_data = bus.ctrl_in;
      3'b010:  sel_data = bus.sat_id_in;
      3'b011:  sel_data = bus.doppler_in;
      3'b100:  sel_data = bus.ca_phase_in[7:0];
      3'b101:  sel_data = bus.ca_phase_in[15:8];
      3'b110:  sel_data = bus.snr_in;
      default: sel_data = 8'h00;
    endcase
  end

  always_comb begin
    cur_byte = {5'b00000, addr_q};
    case (byte_idx)
      2'd1:    cur_byte = data_q;
`ifdef READBACK_CHECKSUM_EN
      2'd2:    cur_byte = {5'b00000, addr_q} ^ data_q;
`endif
      default: cur_byte = {5'b00000, addr_q};
    endcase
  end

  assign bit_done = (bit_cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      // NOTE: snapshot registers are cleared too, so an aborted frame leaves no stale data behind.
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx_q    <= 1'b1;
          if (bus.rd_req_in) begin
            addr_q   <= bus.rd_addr_in;
            data_q   <= sel_data;
            byte_idx <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= cur_byte[0];
            shift_q <= cur_byte >> 1;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              // next start bit follows the stop bit with no idle gap
              byte_idx <= byte_idx + 1'b1;
              tx_q     <= 1'b0;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_out   = tx_q;
  assign bus.busy_out = busy_q;

endmodule

// File: tb/tb_reg_readback_tx.sv
// Scoreboard bench for reg_readback_tx: requests push expected bytes and busy
// lengths; a UART decoder and a busy monitor pop and compare independently.
module tb_reg_readback_tx;

  localparam int CPB = 4;
`ifdef READBACK_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic clk_in   = 1'b0;
  logic rst_in_n = 1'b0;

  reg_readback_tx_if bus ();

  reg_readback_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         busy_q[$];
  int         edge_cnt  = 0;
  int         next_free = 0;

  always @(posedge clk_in) edge_cnt++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Register map as a plain lookup table.
  function automatic logic [7:0] ref_data(input logic [2:0] a);
    case (a)
      3'd0:    return bus.ctrl_in;
      3'd2:    return bus.sat_id_in;
      3'd3:    return bus.doppler_in;
      3'd4:    return bus.ca_phase_in[7:0];
      3'd5:    return bus.ca_phase_in[15:8];
      3'd6:    return bus.snr_in;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [2:0] a);
    int         nxt;
    logic       acc;
    logic [7:0] d;
    nxt = edge_cnt + 1;
    acc = rst_in_n && (nxt >= next_free);
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = a;
    if (acc) begin
      d = ref_data(a);
      exp_q.push_back({5'b00000, a});
      exp_q.push_back(d);
`ifdef READBACK_CHECKSUM_EN
      exp_q.push_back({5'b00000, a} ^ d);
`endif
      busy_q.push_back(FRAME);
      next_free = nxt + FRAME + 1;
    end
    step();
    bus.rd_req_in = 1'b0;
    if (acc) begin
      check("start_bit_after_accept", bus.tx_out, 1'b0);
      check("busy_after_accept", bus.busy_out, 1'b1);
    end
  endtask

  task automatic wait_free();
    while (edge_cnt + 1 < next_free) step();
    repeat (2) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_in_n       = 1'b0;
    bus.rd_req_in  = 1'b1;
    bus.rd_addr_in = 3'd3;
    exp_q.delete();
    busy_q.delete();
    next_free = 0;
    step();
    check("reset_tx_high", bus.tx_out, 1'b1);
    check("reset_busy_low", bus.busy_out, 1'b0);
    repeat (cycles - 1) step();
    rst_in_n      = 1'b1;
    bus.rd_req_in = 1'b0;
  endtask

  task automatic rand_regs();
    bus.ctrl_in     = 8'($urandom);
    bus.sat_id_in   = 8'($urandom);
    bus.doppler_in  = 8'($urandom);
    bus.ca_phase_in = 16'($urandom);
    bus.snr_in      = 8'($urandom);
  endtask

  // UART decoder: samples mid-bit on the falling clock edge.
  logic       dec_active = 1'b0;
  int         pos        = 0;
  logic [9:0] bits       = '0;

  always @(negedge clk_in) begin
    if (!rst_in_n) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (bus.tx_out == 1'b0) begin
        dec_active = 1'b1;
        pos        = 0;
      end
    end else begin
      pos++;
      if (pos % CPB == CPB / 2) bits[pos / CPB] = bus.tx_out;
      if (pos == 9 * CPB + CPB / 2) begin
        check("start_bit", bits[0], 1'b0);
        check("stop_bit", bits[9], 1'b1);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", bits[8:1], 32'hFFFF_FFFF);
        end else begin
          check("rx_byte", bits[8:1], exp_q.pop_front());
        end
        dec_active = 1'b0;
      end
    end
  end

  // Busy monitor: measures each busy pulse in clock cycles.
  int   busy_len  = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk_in) begin
    if (!rst_in_n) begin
      busy_len  = 0;
      busy_prev = 1'b0;
    end else begin
      if (bus.busy_out) begin
        busy_len++;
      end else if (busy_prev) begin
        if (busy_q.size() == 0) check("unexpected_busy", busy_len, 0);
        else check("busy_length", busy_len, busy_q.pop_front());
        busy_len = 0;
      end
      busy_prev = bus.busy_out;
    end
  end

  initial begin
    int idle_bad;
    int gap;
    bus.rd_req_in  = 1'b0;
    bus.rd_addr_in = 3'd0;
    bus.ctrl_in     = 8'hA5;
    bus.sat_id_in   = 8'h17;
    bus.doppler_in  = 8'hC0;
    bus.ca_phase_in = 16'h1234;
    bus.snr_in      = 8'h10;

    // Reset with a request held high: must be ignored.
    do_reset(3);
    step();
    check("idle_after_first_reset", {bus.tx_out, bus.busy_out}, 2'b10);

    // Doppler readback.
    bus.doppler_in = 8'hC0;
    issue(3'd3);
    wait_free();

    // CA phase lo/hi, with a dropped request while busy.
    bus.ca_phase_in = 16'h1234;
    issue(3'd4);
    repeat (10) step();
    issue(3'd5);
    check("busy_during_drop", bus.busy_out, 1'b1);
    while (edge_cnt + 1 < next_free - 1) step();
    issue(3'd5);
    issue(3'd5);
    wait_free();

    // Unmapped addresses.
    issue(3'd7);
    wait_free();
    issue(3'd1);
    wait_free();

    // Snapshot: SNR changes the cycle after acceptance.
    bus.snr_in = 8'h10;
    issue(3'd6);
    bus.snr_in = 8'h55;
    wait_free();

    // Reset during the data byte aborts the frame.
    bus.sat_id_in = 8'h3C;
    issue(3'd2);
    repeat (14 * CPB) step();
    do_reset(2);
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0) idle_bad++;
    end
    check("idle_after_abort", idle_bad, 0);

    // Randomized traffic, including requests while busy and mid-frame input changes.
    for (int i = 0; i < 40; i++) begin
      rand_regs();
      issue(3'($urandom_range(0, 7)));
      gap = $urandom_range(0, FRAME + 10);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 7) == 0) rand_regs();
        step();
      end
    end
    wait_free();
    repeat (2 * CPB) step();

    check("bytes_outstanding", exp_q.size(), 0);
    check("busy_outstanding", busy_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_readback_tx.md
REG_READBACK_TX -- requirements
Module: reg_readback_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 142, meaning clock cycles per UART bit (16368000/115200).
REQ-002 SHALL have port clk_in  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_in_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rd_req_in  input  1  read request, single-cycle strobe.
REQ-005 SHALL have port rd_addr_in  input  3  register address, sampled with rd_req_in.
REQ-006 SHALL have port ctrl_in  input  8  control register value.
REQ-007 SHALL have port sat_id_in  input  8  satellite ID register value.
REQ-008 SHALL have port doppler_in  input  8  Doppler register value.
REQ-009 SHALL have port ca_phase_in  input  16  CA phase, {hi,lo}.
REQ-010 SHALL have port snr_in  input  8  SNR register value.
REQ-011 SHALL have port tx_out  output  1  UART serial line, idle high.
REQ-012 SHALL have port busy_out  output  1  high while a response frame is in progress.

Function
REQ-013 SHALL map addresses: 000 ctrl, 010 sat_id, 011 doppler, 100 ca_phase[7:0], 101 ca_phase[15:8], 110 snr; 001 and 111 read 0x00.
REQ-014 SHALL accept rd_req_in only when busy_out is low; requests while busy are dropped with no side effect.
REQ-015 SHALL snapshot address and selected data on the accepting edge; later input changes do not alter the frame.
REQ-016 SHALL transmit a response of two bytes: address byte {5'b00000, addr}, then data byte.
REQ-017 SHALL send each byte as 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-018 SHALL drive tx_out low (start bit) on the cycle after acceptance; busy_out high on that same cycle.
REQ-019 SHALL send consecutive bytes back-to-back with no idle gap after the stop bit.
REQ-020 SHALL hold busy_out high until the final stop bit has completed its full CLKS_PER_BIT cycles, then drop it; a new request is acceptable on the cycle busy_out is low.
REQ-021 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START on accept; START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START if bytes remain, else IDLE.
REQ-022 SHALL use a bit-time counter of width ceil(log2(CLKS_PER_BIT)) wrapping at CLKS_PER_BIT-1, a 3-bit bit index, and a byte index.
REQ-023 SHALL hold tx_out high whenever in IDLE.

Reset
REQ-024 SHALL on rst_in_n low at a clock edge: state IDLE, tx_out 1, busy_out 0, all counters and snapshot registers 0.
REQ-025 SHALL abort any frame in progress on reset, tx_out returning high at that edge; no partial frame resumes.
REQ-026 SHALL ignore rd_req_in on any edge where rst_in_n is low.

Configuration
REQ-027 SHALL, with macro READBACK_CHECKSUM_EN defined, append a third byte equal to address byte XOR data byte, frame length 3 bytes.
REQ-028 SHALL, without READBACK_CHECKSUM_EN, send exactly two bytes and contain no checksum logic.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 SHALL cover: doppler_in=0xC0, rd_req addr 011 -> bytes 0x03, 0xC0 decoded; busy_out high exactly 80 cycles (without checksum).
REQ-030 SHALL cover: ca_phase_in=0x1234, reads of 100 then 101 -> data bytes 0x34, then 0x12; second request issued while busy is dropped, re-issued after busy low is served.
REQ-031 SHALL cover: read addr 111 -> bytes 0x07, 0x00; read addr 001 -> 0x01, 0x00.
REQ-032 SHALL cover: snr_in changed from 0x10 to 0x55 one cycle after accepting addr 110 -> data byte 0x10.
REQ-033 SHALL cover: rst_in_n low during the data byte -> tx_out 1 and busy_out 0 at that edge, stays idle after release with no request.
REQ-034 SHALL cover with READBACK_CHECKSUM_EN: addr 011, doppler 0xC0 -> bytes 0x03, 0xC0, 0xC3; busy_out high 120 cycles.
